// File: rtl/clk_phase_gen_pkg.sv
// Shared constants for the four-phase clock generator: FSM state codes,
// phase-decode masks and the derived-clock bundle type.
package clk_phase_gen_pkg;

   // FSM state codes
   localparam logic [1:0] ST_RESET  = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   // Phase counter limits; a period boundary is the ph 3 -> 0 wrap
   localparam logic [1:0] PH_FIRST = 2'd0;
   localparam logic [1:0] PH_LAST  = 2'd3;

   // Bit n of a mask set => that clock is high while ph == n.
   // Each clock is high for two consecutive phases, staggered by one.
   localparam logic [3:0] IMEM_PH_MASK = 4'b0011;   // ph 0,1
   localparam logic [3:0] REGF_PH_MASK = 4'b0110;   // ph 1,2
   localparam logic [3:0] DMEM_PH_MASK = 4'b1100;   // ph 2,3
   localparam logic [3:0] PROC_PH_MASK = 4'b1001;   // ph 3,0

   // Hold counter width covers RST_HOLD up to 255
   localparam int unsigned HOLD_CNT_W = 8;

   typedef struct packed {
      logic imem;
      logic regf;
      logic dmem;
      logic proc;
   } dclk_t;

   localparam dclk_t DCLK_OFF = '{imem: 1'b0, regf: 1'b0, dmem: 1'b0, proc: 1'b0};

   // Level of every derived clock while the phase counter reads ph
   function automatic dclk_t phase_decode(input logic [1:0] ph);
      dclk_t d;
      d.imem = IMEM_PH_MASK[ph];
      d.regf = REGF_PH_MASK[ph];
      d.dmem = DMEM_PH_MASK[ph];
      d.proc = PROC_PH_MASK[ph];
      return d;
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset release synchronizer. Assertion is asynchronous, release
// is retimed to the clock. rel is the synchronized release; rel_next is the
// value rel will take on the coming edge, so the consumer can act on the
// same edge rel rises.
module reset_sync (
   input  logic clock,
   input  logic reset,
   output logic rel_next,
   output logic rel
);

   logic s1_q;
   logic s2_q;

   // Shift a constant one through two stages once reset is released
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= 1'b1;
         s2_q <= s1_q;
      end
   end

   assign rel_next = s1_q;
   assign rel      = s2_q;

endmodule

// File: rtl/clk_phase_gen.sv
// Four-phase derived clock generator with reset sequencing and halt.
// After reset release the core is held in reset for RST_HOLD full phase
// periods while the derived clocks already run, then released into RUN.
// halt_req freezes all derived clocks at the next period boundary.
module clk_phase_gen
   import clk_phase_gen_pkg::*;
#(
   parameter int unsigned RST_HOLD = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        halt_req,
   output logic        imem_clock,
   output logic        regfile_clock,
   output logic        dmem_clock,
   output logic        processor_clock,
   output logic        core_reset,
   output logic        halted,
   output logic [31:0] cycle_count
);

   generate
      if (RST_HOLD < 1 || RST_HOLD > 255) begin : g_bad_hold
         $error("clk_phase_gen: RST_HOLD must be in 1..255");
      end
   endgenerate

   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RST_HOLD - 1);

   logic                  rel_next;
   logic                  rel;
   logic [1:0]            state_q, state_d;
   logic [1:0]            ph_q, ph_d;
   logic [HOLD_CNT_W-1:0] hold_q, hold_d;
   logic                  cnt_inc;
   logic [31:0]           cnt_q;
   dclk_t                 dclk_q, dclk_d;
   logic                  core_reset_d;
   logic                  halted_d;

   reset_sync u_reset_sync (
      .clock    (clock),
      .reset    (reset),
      .rel_next (rel_next),
      .rel      (rel)
   );

   // Next-state, phase and hold-count decode
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      hold_d  = hold_q;
      cnt_inc = 1'b0;
      case (state_q)
         ST_RESET: begin
            // Leave on the edge where the synchronizer output rises
            ph_d = PH_FIRST;
            if (rel_next && !rel) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // halt_req is deliberately not looked at until RUN
            ph_d = ph_q + 2'd1;
            if (ph_q == PH_LAST) begin
               hold_d = hold_q + 1'b1;
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            ph_d = ph_q + 2'd1;
            if (ph_q == PH_LAST) begin
               // The period ending on the halting edge still counts
               cnt_inc = 1'b1;
               if (halt_req) begin
                  state_d = ST_HALTED;
               end
            end
         end
         ST_HALTED: begin
            // Resume at ph 0 so imem_clock rises on the release edge
            ph_d = PH_FIRST;
            if (!halt_req) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RESET;
            ph_d    = PH_FIRST;
         end
      endcase
   end

   // Output decode from next state so every output comes straight off a flop
   always_comb begin
      dclk_d       = DCLK_OFF;
      core_reset_d = 1'b1;
      halted_d     = 1'b0;
      if (state_d == ST_HOLD || state_d == ST_RUN) begin
         dclk_d = phase_decode(ph_d);
      end
      if (state_d == ST_RUN || state_d == ST_HALTED) begin
         core_reset_d = 1'b0;
      end
      if (state_d == ST_HALTED) begin
         halted_d = 1'b1;
      end
   end

   // FSM, phase and hold counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RESET;
         ph_q    <= PH_FIRST;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         hold_q  <= hold_d;
      end
   end

   // Registered outputs; core_reset asserts together with the async reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dclk_q     <= DCLK_OFF;
         core_reset <= 1'b1;
         halted     <= 1'b0;
      end else begin
         dclk_q     <= dclk_d;
         core_reset <= core_reset_d;
         halted     <= halted_d;
      end
   end

   // Completed processor periods; only written on a counted wrap
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (cnt_inc) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign imem_clock      = dclk_q.imem;
   assign regfile_clock   = dclk_q.regf;
   assign dmem_clock      = dclk_q.dmem;
   assign processor_clock = dclk_q.proc;
   assign cycle_count     = cnt_q;

   // Opposite clocks are complementary while running, all low otherwise
   a_imem_dmem_compl : assert property (@(posedge clock) disable iff (!reset)
      (imem_clock ^ dmem_clock) ||
      !(imem_clock || regfile_clock || dmem_clock || processor_clock));

   a_regf_proc_compl : assert property (@(posedge clock) disable iff (!reset)
      (regfile_clock ^ processor_clock) ||
      !(imem_clock || regfile_clock || dmem_clock || processor_clock));

   // A halted core is out of reset with every derived clock parked low
   a_halted_quiet : assert property (@(posedge clock) disable iff (!reset)
      halted |-> !(imem_clock || regfile_clock || dmem_clock ||
                   processor_clock || core_reset));

endmodule

// File: tb/tb_clk_phase_gen.sv
// Bench for clk_phase_gen: hand-derived vector table for the startup / halt
// sequence, hand-written async reset and preload sequences, then randomized
// halt/reset traffic checked cycle by cycle against a behavioural model.
module tb_clk_phase_gen;

   localparam int unsigned RST_HOLD = 4;

   logic        clock;
   logic        reset;
   logic        halt_req;
   logic        imem_clock;
   logic        regfile_clock;
   logic        dmem_clock;
   logic        processor_clock;
   logic        core_reset;
   logic        halted;
   logic [31:0] cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   clk_phase_gen #(.RST_HOLD(RST_HOLD)) dut (
      .clock           (clock),
      .reset           (reset),
      .halt_req        (halt_req),
      .imem_clock      (imem_clock),
      .regfile_clock   (regfile_clock),
      .dmem_clock      (dmem_clock),
      .processor_clock (processor_clock),
      .core_reset      (core_reset),
      .halted          (halted),
      .cycle_count     (cycle_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   // Tracks edges since release, remaining hold cycles, a phase 0..3 and
   // the period counter; clocks are derived from phase arithmetic.
   bit          m_rst_on;
   int          m_sync;
   int          m_hold_left;
   int          m_ph;
   bit          m_run;
   bit          m_halt;
   logic [31:0] m_cnt;

   function automatic bit dclk_hi(input int ph, input int offs);
      return ((ph - offs + 4) % 4) < 2;
   endfunction

   task automatic model_reset();
      m_rst_on = 1'b1;
      m_sync   = 0;
      m_run    = 1'b0;
      m_halt   = 1'b0;
      m_ph     = 0;
      m_cnt    = 32'd0;
   endtask

   task automatic model_release();
      m_rst_on = 1'b0;
   endtask

   task automatic model_edge(input bit hreq);
      if (m_rst_on) return;
      if (m_sync < 2) begin
         m_sync++;
         if (m_sync == 2) begin
            m_ph        = 0;
            m_hold_left = 4 * RST_HOLD;
            m_run       = 1'b0;
         end
         return;
      end
      if (!m_run) begin
         m_ph = (m_ph + 1) % 4;
         m_hold_left--;
         if (m_hold_left == 0) m_run = 1'b1;
         return;
      end
      if (m_halt) begin
         if (!hreq) m_halt = 1'b0;
         return;
      end
      if (m_ph == 3) begin
         m_cnt = m_cnt + 32'd1;
         if (hreq) m_halt = 1'b1;
      end
      m_ph = (m_ph + 1) % 4;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      bit in_seq, e_run, e_hl, act;
      in_seq = !m_rst_on && (m_sync >= 2);
      e_run  = in_seq && m_run;
      e_hl   = e_run && m_halt;
      act    = in_seq && !e_hl;
      chk1({tag, ".imem"}, imem_clock,      act && dclk_hi(m_ph, 0));
      chk1({tag, ".regf"}, regfile_clock,   act && dclk_hi(m_ph, 1));
      chk1({tag, ".dmem"}, dmem_clock,      act && dclk_hi(m_ph, 2));
      chk1({tag, ".proc"}, processor_clock, act && dclk_hi(m_ph, 3));
      chk1({tag, ".core_reset"}, core_reset, !e_run);
      chk1({tag, ".halted"}, halted, e_hl);
      chk32({tag, ".cycle_count"}, cycle_count, m_cnt);
   endtask

   // One clock: drive at negedge, model the posedge, land on next negedge
   task automatic step(input bit hreq);
      halt_req = hreq;
      @(posedge clock);
      model_edge(hreq);
      @(negedge clock);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          n;       // edges to apply
      bit          hreq;    // halt_req during those edges
      bit [3:0]    clks;    // expected {imem, regf, dmem, proc}
      bit          cr;      // expected core_reset
      bit          hl;      // expected halted
      logic [31:0] cnt;     // expected cycle_count
   } vec_t;

   vec_t vecs[$];

   initial begin
      bit hreq_r;
      bit found;
      int k_fall;

      // edge numbers below count rising edges after reset release
      vecs.push_back('{1,  1'b0, 4'b0000, 1'b1, 1'b0, 32'd0});  // e1 still syncing
      vecs.push_back('{1,  1'b0, 4'b1001, 1'b1, 1'b0, 32'd0});  // e2 HOLD ph0
      vecs.push_back('{1,  1'b0, 4'b1100, 1'b1, 1'b0, 32'd0});  // ph1
      vecs.push_back('{1,  1'b0, 4'b0110, 1'b1, 1'b0, 32'd0});  // ph2
      vecs.push_back('{1,  1'b0, 4'b0011, 1'b1, 1'b0, 32'd0});  // ph3
      vecs.push_back('{12, 1'b1, 4'b0011, 1'b1, 1'b0, 32'd0});  // e17, halt ignored in HOLD
      vecs.push_back('{1,  1'b0, 4'b1001, 1'b0, 1'b0, 32'd0});  // e18 RUN ph0
      vecs.push_back('{3,  1'b0, 4'b0011, 1'b0, 1'b0, 32'd0});  // e21 ph3
      vecs.push_back('{1,  1'b0, 4'b1001, 1'b0, 1'b0, 32'd1});  // e22 first wrap
      vecs.push_back('{37, 1'b0, 4'b1100, 1'b0, 1'b0, 32'd10}); // e59 ph1, 40 cycles in RUN
      vecs.push_back('{1,  1'b1, 4'b0110, 1'b0, 1'b0, 32'd10}); // halt raised at ph1
      vecs.push_back('{1,  1'b1, 4'b0011, 1'b0, 1'b0, 32'd10}); // ph3, not yet halted
      vecs.push_back('{1,  1'b1, 4'b0000, 1'b0, 1'b1, 32'd11}); // e62 HALTED, wrap counted
      vecs.push_back('{3,  1'b1, 4'b0000, 1'b0, 1'b1, 32'd11}); // frozen
      vecs.push_back('{1,  1'b0, 4'b1001, 1'b0, 1'b0, 32'd11}); // resume ph0
      vecs.push_back('{1,  1'b0, 4'b1100, 1'b0, 1'b0, 32'd11}); // ph1
      vecs.push_back('{3,  1'b0, 4'b1001, 1'b0, 1'b0, 32'd12}); // counting resumed
      vecs.push_back('{3,  1'b1, 4'b0011, 1'b0, 1'b0, 32'd12}); // halt only at ph0..2
      vecs.push_back('{1,  1'b0, 4'b1001, 1'b0, 1'b0, 32'd13}); // dropped before ph3 edge

      reset    = 1'b0;
      halt_req = 1'b0;
      model_reset();

      // reset state
      @(negedge clock);
      check_model("reset");
      chk1("reset.core_reset_const", core_reset, 1'b1);
      chk32("reset.cycle_count_const", cycle_count, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      model_release();

      // table-driven startup, run, halt and resume
      foreach (vecs[i]) begin
         repeat (vecs[i].n) step(vecs[i].hreq);
         chk1($sformatf("vec%0d.imem", i), imem_clock,      vecs[i].clks[3]);
         chk1($sformatf("vec%0d.regf", i), regfile_clock,   vecs[i].clks[2]);
         chk1($sformatf("vec%0d.dmem", i), dmem_clock,      vecs[i].clks[1]);
         chk1($sformatf("vec%0d.proc", i), processor_clock, vecs[i].clks[0]);
         chk1($sformatf("vec%0d.core_reset", i), core_reset, vecs[i].cr);
         chk1($sformatf("vec%0d.halted", i), halted, vecs[i].hl);
         chk32($sformatf("vec%0d.cycle_count", i), cycle_count, vecs[i].cnt);
      end

      // reset mid-RUN at ph2: outputs must react without a clock edge
      step(1'b0);
      step(1'b0);
      chk1("midrun.dmem_before", dmem_clock, 1'b1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk1("midrun.imem", imem_clock, 1'b0);
      chk1("midrun.regf", regfile_clock, 1'b0);
      chk1("midrun.dmem", dmem_clock, 1'b0);
      chk1("midrun.proc", processor_clock, 1'b0);
      chk1("midrun.core_reset", core_reset, 1'b1);
      chk32("midrun.cycle_count", cycle_count, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      model_release();

      // core_reset must fall on the 18th edge after release
      k_fall = 0;
      for (int k = 1; k <= 100; k++) begin
         step(1'b0);
         check_model("restart");
         if (core_reset === 1'b0) begin
            k_fall = k;
            break;
         end
      end
      chk32("restart.fall_edge", 32'(k_fall), 32'd18);
      chk32("restart.cycle_count", cycle_count, 32'd0);

      // randomized halt and reset traffic against the model
      hreq_r = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) hreq_r = ~hreq_r;
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            model_reset();
            #1;
            check_model("rnd_async");
            repeat ($urandom_range(1, 3)) begin
               step(hreq_r);
               check_model("rnd_in_reset");
            end
            reset = 1'b1;
            model_release();
         end else begin
            step(hreq_r);
            check_model("rnd");
         end
      end

      // counter wrap: preload all ones mid-period, next wrap gives zero
      reset = 1'b0;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      model_release();
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         step(1'b0);
         if (m_run && m_ph == 1) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL preload.reach: RUN ph1 not reached within 200 cycles");
      end else begin
         force dut.cnt_q = 32'hFFFF_FFFF;
         step(1'b0);
         release dut.cnt_q;
         m_cnt = 32'hFFFF_FFFF;
         check_model("preload");
         step(1'b0);
         check_model("preload_ph3");
         step(1'b0);
         check_model("preload_wrap");
         chk32("preload.wrap_zero", cycle_count, 32'd0);
         step(1'b0);
         check_model("preload_after");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_phase_gen.md
CLK_PHASE_GEN -- requirements
Module: clk_phase_gen

Interface
REQ-001 Parameter: RST_HOLD, default 4, number of full 4-cycle phase periods that core_reset stays high after reset release (legal range 1..255).
REQ-002 clock  input  1  single system clock; all flops rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 halt_req  input  1  level request to freeze all derived clocks at the next period boundary.
REQ-005 imem_clock  output  1  instruction-memory clock, period 4 clock cycles.
REQ-006 regfile_clock  output  1  register-file clock, period 4 clock cycles.
REQ-007 dmem_clock  output  1  data-memory clock, period 4 clock cycles.
REQ-008 processor_clock  output  1  processor (PC/pipeline) clock, period 4 clock cycles.
REQ-009 core_reset  output  1  active-high synchronous reset to the core; asserts asynchronously, deasserts via the state machine.
REQ-010 halted  output  1  high while derived clocks are frozen by halt_req.
REQ-011 cycle_count  output  32  count of completed processor periods in RUN.

Function
REQ-012 A 2-bit phase counter ph shall increment by 1 mod 4 on every clock edge in HOLD and RUN, and shall hold 0 in RESET and HALTED.
REQ-013 Derived clocks, 50% duty, staggered one cycle: imem high at ph 0,1; regfile high at ph 1,2; dmem high at ph 2,3; processor high at ph 3,0.
REQ-014 Every derived clock and core_reset shall be driven directly from a flop (registered from next-state decode); no combinational decode on outputs.
REQ-015 States: RESET, HOLD, RUN, HALTED.
REQ-016 RESET -> HOLD on the first edge after the 2-flop reset synchronizer outputs deassertion; ph = 0 in the first HOLD cycle.
REQ-017 In HOLD, derived clocks toggle per REQ-013 and core_reset = 1; hold counter increments on each ph 3->0 wrap.
REQ-018 HOLD -> RUN on the edge where ph = 3 and hold counter = RST_HOLD-1; core_reset = 0 from that edge; ph wraps to 0.
REQ-019 RUN -> HALTED on the edge where ph = 3 and halt_req = 1; halt_req at any other ph has no effect until ph = 3.
REQ-020 In HALTED, all four derived clocks = 0, ph = 0, halted = 1, core_reset = 0, cycle_count held.
REQ-021 HALTED -> RUN on the first edge with halt_req = 0; halted = 0 and ph = 0 (imem_clock high) from that edge.
REQ-022 cycle_count shall increment by 1 on every ph 3->0 wrap in RUN, including the RUN->HALTED edge; it wraps 0xFFFFFFFF -> 0.
REQ-023 halt_req is ignored in RESET and HOLD; HOLD always completes into RUN first.

Reset
REQ-024 reset low shall asynchronously force state = RESET, ph = 0, all derived clocks = 0, core_reset = 1, halted = 0, cycle_count = 0, hold counter = 0, synchronizer flops = 0.
REQ-025 Reset assertion mid-HOLD, mid-RUN or in HALTED shall abort immediately per REQ-024 and restart the full sequence from RESET on release.
REQ-026 Reset release shall be synchronized through two flops; the earliest HOLD entry is on the 2nd rising edge after reset goes high.

Structure
REQ-027 State encoding localparams (RESET, HOLD, RUN, HALTED) and the phase-decode constants shall live in a shared package/include used by the skeleton top level.
REQ-028 The 2-flop reset synchronizer shall be a separate sub-module, reset_sync, instantiated once.
REQ-029 The skeleton top level shall take imem_clock, dmem_clock, processor_clock, regfile_clock exclusively from this block.

Verification
REQ-030 reset low 2 cycles, then high, RST_HOLD=4 -> core_reset high for 2 sync cycles plus 16 HOLD cycles, falls on edge after ph=3 of 4th period; cycle_count = 0.
REQ-031 Free run 40 cycles after RUN -> each derived clock period = 4 cycles, duty 2/2, rising-edge order imem, regfile, dmem, processor; cycle_count = 10.
REQ-032 halt_req pulsed high at ph=1 and held -> HALTED entered only after ph=3 edge; all clocks 0, halted = 1, cycle_count frozen.
REQ-033 halt_req dropped in HALTED -> next edge halted = 0, imem_clock = 1, ph = 0, counting resumes from held value.
REQ-034 reset asserted mid-RUN at ph=2 -> same timestep all clocks 0, core_reset = 1, cycle_count = 0; release repeats REQ-030 timing.
REQ-035 cycle_count forced to 0xFFFFFFFF via preload in the bench -> next wrap yields 0 with no other output disturbance.
